// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the LED sequencer.
// Holds the pattern mode and FSM state enums, the field layout of the
// HPS LED register export, and the helper that computes the pattern
// loaded when a new command is accepted.
package led_seq_pkg;

  // Widths of the register export and the LED drive.
  localparam int LEDREG_W   = 8;
  localparam int LED_W      = 8;

  // Field layout of ledreg: [7:6] mode, [5:3] speed, [2:0] seed.
  localparam int MODE_LSB   = 6;
  localparam int MODE_W     = 2;
  localparam int SPEED_LSB  = 3;
  localparam int SPEED_W    = 3;
  localparam int SEED_LSB   = 0;
  localparam int SEED_W     = 3;

  // Base ticks per step go up to 8, so a 3-bit counter (0..7) is enough.
  localparam int STEP_CNT_W = 3;

  typedef enum logic [MODE_W-1:0] {
    DIRECT = 2'b00,
    SHIFT  = 2'b01,
    BOUNCE = 2'b10,
    BLINK  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    HOLD = 2'b11
  } state_e;

  // Pattern shown right after a command is accepted.
  // DIRECT shows the low six register bits, SHIFT/BOUNCE light the seed
  // position, BLINK starts fully lit.
  function automatic logic [LED_W-1:0] load_pattern(input logic [LEDREG_W-1:0] cmd);
    logic [LED_W-1:0] pat;
    pat = '0;
    case (mode_e'(cmd[MODE_LSB +: MODE_W]))
      DIRECT:        pat = {{MODE_W{1'b0}}, cmd[MODE_LSB-1:0]};
      SHIFT, BOUNCE: pat = 8'h01 << cmd[SEED_LSB +: SEED_W];
      BLINK:         pat = 8'hFF;
      default:       pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_seq_tick.sv
// led_seq_tick: step timing for the LED sequencer.
// A prescaler divides the clock by BASE_DIV into base ticks, and a small
// counter groups (8 - speed) base ticks into one step. Clearing restarts
// the whole interval; dropping enable freezes both counters so a paused
// sequence resumes with the remainder of its interval intact.
module led_seq_tick
  import led_seq_pkg::*;
#(
  parameter int BASE_DIV = 781250
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_clear,
  input  logic               i_enable,
  input  logic [SPEED_W-1:0] i_speed,
  output logic               o_step
);

  // A divide-by-1 prescaler still needs a one-bit register.
  localparam int PRESC_W = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(BASE_DIV - 1);

  logic [PRESC_W-1:0]    r_presc;
  logic [STEP_CNT_W-1:0] r_step_cnt;
  logic                  w_base_tick;
  logic [STEP_CNT_W-1:0] w_step_last;

  // A step spans (8 - speed) base ticks, so the counter's last value is 7 - speed.
  assign w_step_last = 3'd7 - i_speed;
  assign w_base_tick = i_enable && (r_presc == PRESC_LAST);
  assign o_step      = w_base_tick && (r_step_cnt == w_step_last);

  // Prescaler and base-tick counter; both wrap on a step so no value overflows.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_presc    <= '0;
      r_step_cnt <= '0;
    end else if (i_clear) begin
      r_presc    <= '0;
      r_step_cnt <= '0;
    end else if (i_enable) begin
      if (w_base_tick) begin
        r_presc    <= '0;
        r_step_cnt <= o_step ? '0 : r_step_cnt + 1'b1;
      end else begin
        r_presc    <= r_presc + 1'b1;
      end
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: LED pattern sequencer driven by the HPS LED register.
// The register is sampled every cycle; any change reloads the pattern
// two cycles later and restarts step timing. Patterns then advance by
// SHIFT, BOUNCE or BLINK rules, while DIRECT simply shows the register.
// Define LED_SEQ_PAUSE_EN to add the pause_n input and the HOLD state.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int BASE_DIV = 781250
) (
  input  logic                clk_clk,
  input  logic                reset_reset_n,
  input  logic [LEDREG_W-1:0] ledreg_i,
`ifdef LED_SEQ_PAUSE_EN
  input  logic                pause_n,
`endif
  output logic [LED_W-1:0]    led_o,
  output logic                step_o,
  output logic                busy_o
);

  state_e               r_state;
  state_e               w_next_state;
  logic [LEDREG_W-1:0]  r_cmd;
  logic [LED_W-1:0]     r_led;
  logic                 r_step;
  logic                 r_dir_left;

  logic                 w_change;
  logic                 w_pause_n;
  mode_e                w_mode;
  logic [SPEED_W-1:0]   w_speed;
  logic                 w_tick_clear;
  logic                 w_tick_enable;
  logic                 w_step;
  logic [LED_W-1:0]     w_stepped_led;
  logic                 w_next_dir_left;

`ifdef LED_SEQ_PAUSE_EN
  assign w_pause_n = pause_n;
`else
  assign w_pause_n = 1'b1;
`endif

  assign w_change = (ledreg_i != r_cmd);
  assign w_mode   = mode_e'(r_cmd[MODE_LSB +: MODE_W]);
  assign w_speed  = r_cmd[SPEED_LSB +: SPEED_W];

  // Timing restarts while loading; a pending command change beats a step.
  assign w_tick_clear  = (r_state == LOAD);
  assign w_tick_enable = (r_state == RUN) && (w_mode != DIRECT) && !w_change;

  led_seq_tick #(
    .BASE_DIV (BASE_DIV)
  ) u_tick (
    .i_clk    (clk_clk),
    .i_rst_n  (reset_reset_n),
    .i_clear  (w_tick_clear),
    .i_enable (w_tick_enable),
    .i_speed  (w_speed),
    .o_step   (w_step)
  );

  // Command capture and FSM state register.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_cmd   <= '0;
      r_state <= IDLE;
    end else begin
      r_cmd   <= ledreg_i;
      r_state <= w_next_state;
    end
  end

  // Next state: a command change always forces a reload, from any state.
  always_comb begin
    w_next_state = r_state;
    if (w_change) begin
      w_next_state = LOAD;
    end else begin
      case (r_state)
        IDLE:    w_next_state = IDLE;
        LOAD:    w_next_state = w_pause_n ? RUN : HOLD;
        RUN:     if (!w_pause_n) w_next_state = HOLD;
        HOLD:    if (w_pause_n) w_next_state = RUN;
        default: w_next_state = IDLE;
      endcase
    end
  end

  // Pattern advance for one step; BOUNCE turns around at either end so the
  // lit bit never shifts out.
  always_comb begin
    w_stepped_led   = r_led;
    w_next_dir_left = r_dir_left;
    case (w_mode)
      SHIFT: w_stepped_led = {r_led[LED_W-2:0], r_led[LED_W-1]};
      BLINK: w_stepped_led = ~r_led;
      BOUNCE: begin
        if (r_dir_left) begin
          if (r_led[LED_W-1]) begin
            w_stepped_led   = r_led >> 1;
            w_next_dir_left = 1'b0;
          end else begin
            w_stepped_led   = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_stepped_led   = r_led << 1;
            w_next_dir_left = 1'b1;
          end else begin
            w_stepped_led   = r_led >> 1;
          end
        end
      end
      default: w_stepped_led = r_led;
    endcase
  end

  // LED register: loaded on leaving LOAD, stepped on each step with the
  // step pulse raised in the same cycle the new value appears.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_led      <= '0;
      r_step     <= 1'b0;
      r_dir_left <= 1'b1;
    end else begin
      r_step <= 1'b0;
      if (r_state == LOAD) begin
        r_led      <= load_pattern(r_cmd);
        r_dir_left <= 1'b1;
      end else if (w_step) begin
        r_led      <= w_stepped_led;
        r_dir_left <= w_next_dir_left;
        r_step     <= 1'b1;
      end
    end
  end

  assign led_o  = r_led;
  assign step_o = r_step;
  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: scoreboard bench for the LED sequencer.
// Stimulus pushes the expected (cycle, pattern) of every future step into a
// queue computed from the pattern rules; a monitor pops entries as steps
// come due and also checks the static LED value and busy flag each cycle.
module tb_led_seq_ctrl;

  localparam int BASE_DIV = 4;
  localparam int NEVER    = 32'h7FFF_FFFF;

  logic       clk_clk = 1'b0;
  logic       reset_reset_n;
  logic [7:0] ledreg_i;
`ifdef LED_SEQ_PAUSE_EN
  logic       pause_n;
`endif
  logic [7:0] led_o;
  logic       step_o;
  logic       busy_o;

  typedef struct {
    int         cyc;
    logic [7:0] led;
  } step_t;

  step_t      expQ[$];
  int         cyc      = 0;
  int         nChecks  = 0;
  int         nErrors  = 0;
  logic [7:0] lastExp  = 8'h00;
  int         holdFrom = 0;
  int         busyFrom = NEVER;
  logic [7:0] modelCmd = 8'h00;

  always #5 clk_clk = ~clk_clk;

  // Cycle index: the value seen at a falling edge numbers the preceding rising edge.
  always @(posedge clk_clk) cyc <= cyc + 1;

  led_seq_ctrl #(
    .BASE_DIV (BASE_DIV)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .ledreg_i      (ledreg_i),
`ifdef LED_SEQ_PAUSE_EN
    .pause_n       (pause_n),
`endif
    .led_o         (led_o),
    .step_o        (step_o),
    .busy_o        (busy_o)
  );

  // Pattern after k steps of a command, from the mode rules directly.
  function automatic logic [7:0] modelPattern(input logic [7:0] cmd, input int k);
    int         seed;
    int         t;
    logic [7:0] r;
    seed = int'(cmd[2:0]);
    r    = 8'h00;
    case (cmd[7:6])
      2'b00: r = {2'b00, cmd[5:0]};
      2'b01: r = 8'(1 << ((seed + k) % 8));
      2'b10: begin
        t = (seed + k) % 14;
        if (t > 7) t = 14 - t;
        r = 8'(1 << t);
      end
      default: r = ((k % 2) == 0) ? 8'hFF : 8'h00;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d",
               name, actual, expected, cyc);
    end
  endtask

  // Drive a command and hold it for 'hold' cycles; on a real change the
  // model reloads and schedules the step sequence.
  task automatic applyStimulus(input logic [7:0] cmd, input int hold);
    int    c0;
    int    per;
    step_t e;
    @(negedge clk_clk);
    #1;
    c0       = cyc;
    ledreg_i = cmd;
    if (cmd != modelCmd) begin
      modelCmd = cmd;
      expQ.delete();
      lastExp  = modelPattern(cmd, 0);
      holdFrom = c0 + 2;
      if (busyFrom > c0 + 1) busyFrom = c0 + 1;
      if (cmd[7:6] != 2'b00) begin
        per = BASE_DIV * (8 - int'(cmd[5:3]));
        for (int k = 1; k <= 64; k++) begin
          e.cyc = c0 + 2 + k * per;
          e.led = modelPattern(cmd, k);
          expQ.push_back(e);
        end
      end
    end
    repeat (hold - 1) @(negedge clk_clk);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  // Asynchronous reset in the middle of a cycle, then release with ledreg_i=0.
  task automatic applyReset(input int len);
    @(negedge clk_clk);
    #3;
    reset_reset_n = 1'b0;
    ledreg_i      = 8'h00;
    modelCmd      = 8'h00;
    expQ.delete();
    lastExp       = 8'h00;
    holdFrom      = 0;
    busyFrom      = NEVER;
    #1;
    checkOutput("async_rst_led",  led_o,  0);
    checkOutput("async_rst_step", step_o, 0);
    checkOutput("async_rst_busy", busy_o, 0);
    repeat (len) @(negedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
  endtask

`ifdef LED_SEQ_PAUSE_EN
  // Pause takes hold from the next edge; later steps slide by the pause length.
  task automatic applyPause(input int dur);
    int c;
    @(negedge clk_clk);
    #1;
    c       = cyc;
    pause_n = 1'b0;
    for (int i = 0; i < expQ.size(); i++) begin
      if (expQ[i].cyc > c + 1) expQ[i].cyc = expQ[i].cyc + dur;
    end
    repeat (dur) @(negedge clk_clk);
    #1;
    pause_n = 1'b1;
  endtask
`endif

  // Monitor: pops due steps, flags unexpected pulses, checks LED and busy.
  initial begin
    step_t e;
    forever begin
      @(negedge clk_clk);
      while (expQ.size() > 0 && expQ[0].cyc < cyc) begin
        e = expQ.pop_front();
        lastExp = e.led;
        nChecks++;
        nErrors++;
        $display("[TB] FAIL missed_step: got none, expected step at cycle %0d", e.cyc);
      end
      if (expQ.size() > 0 && expQ[0].cyc == cyc) begin
        e = expQ.pop_front();
        lastExp = e.led;
        checkOutput("step_pulse", step_o, 1);
      end else begin
        checkOutput("no_step", step_o, 0);
      end
      if (cyc >= holdFrom) checkOutput("led", led_o, lastExp);
      checkOutput("busy", busy_o, (cyc >= busyFrom) ? 1 : 0);
    end
  end

  // Hard time limit so the run always ends.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stimulus sequence: directed scenarios, then randomized commands.
  initial begin
    logic [7:0] rcmd;
    int         rhold;
    reset_reset_n = 1'b0;
    ledreg_i      = 8'h00;
`ifdef LED_SEQ_PAUSE_EN
    pause_n       = 1'b1;
`endif
    repeat (3) @(negedge clk_clk);
    #1;
    reset_reset_n = 1'b1;
    $display("[TB] reset released");

    idleCycles(100);

    applyStimulus(8'h7A, 40);
    applyStimulus(8'hBF, 70);
    applyStimulus(8'hC0, 70);
    applyStimulus(8'h7A, 9);
    applyStimulus(8'h45, 30);
    applyStimulus(8'h3F, 50);

`ifdef LED_SEQ_PAUSE_EN
    applyStimulus(8'h7A, 6);
    applyPause(20);
    idleCycles(40);
`endif

    applyStimulus(8'hF8, 10);
    applyReset(4);
    idleCycles(20);

    for (int i = 0; i < 40; i++) begin
      rcmd  = 8'($urandom);
      rhold = int'($urandom_range(1, 100));
      applyStimulus(rcmd, rhold);
    end

    idleCycles(10);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
